// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receiver
// Contents:
//   PARITY_NONE/EVEN/ODD - parity mode constants
//   rx_state_t           - receiver FSM states
//   calc_divisor()       - clocks per oversampling tick, rounded to nearest
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int calc_divisor(input int clk_hz, input int baud, input int ovs);
        longint den;
        longint quo;
        den = longint'(baud) * longint'(ovs);
        quo = (longint'(clk_hz) + den / 2) / den;
        if (quo < 1) begin
            quo = 1;
        end
        return int'(quo);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   wr_en, wr_data    - push request and data
//   rd_en             - pop request (ignored while empty)
//   rd_data, valid    - head entry, non-empty flag
//   count             - occupancy 0..DEPTH
//   overflow          - one-cycle pulse when a push is dropped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             push;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_en & valid;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push    = wr_en & (~full | pop);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en & full & ~pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a FWFT FIFO
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   rx                       - asynchronous serial input, idle high
//   m_data, m_valid, m_ready - FIFO head, non-empty flag, pop request
//   frame_err, parity_err    - one-cycle pulses on bad stop / parity
//   overflow                 - one-cycle pulse when a good byte is dropped
//   count                    - FIFO occupancy
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [DATA_BITS-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int DIV   = calc_divisor(CLK_HZ, BAUD, OVS);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int TW    = $clog2(OVS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 tick_done;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 parity_bad;
    logic                 stop_hold;
    logic                 push;

    // Synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    // Free-running tick divider, re-phased on the start edge so sampling
    // points are centred on the incoming bits.
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if ((state == ST_IDLE && fall) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY == PARITY_EVEN) begin
            parity_bad = (par_bit != (^shreg));
        end else if (PARITY == PARITY_ODD) begin
            parity_bad = (par_bit != ~(^shreg));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_done  = 1'b0;
        if (tick) begin
            tick_done = (tick_cnt == ((state == ST_START) ? HALF_LAST : FULL_LAST));
        end
        case (state)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START:  if (tick_done) state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick_done && bit_cnt == LAST_BIT)
                           state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (tick_done) state_next = ST_STOP;
            // After a bad stop bit, wait for the line to return high.
            ST_STOP:   if (stop_hold ? rx_s : (tick_done && rx_s)) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_hold  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            push       <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            push       <= 1'b0;
            if (state == ST_IDLE) begin
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                stop_hold <= 1'b0;
            end else if (tick) begin
                tick_cnt <= tick_done ? '0 : tick_cnt + TW'(1);
            end
            if (tick_done) begin
                case (state)
                    ST_DATA: begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_bit <= rx_s;
                    ST_STOP: begin
                        if (!stop_hold) begin
                            frame_err  <= ~rx_s;
                            parity_err <= parity_bad;
                            push       <= rx_s & ~parity_bad;
                            stop_hold  <= ~rx_s;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  (shreg),
        .rd_en    (m_ready),
        .rd_data  (m_data),
        .valid    (m_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    // 1.6 MHz / (10 kBd * 16) = 10 clocks per tick, 160 clocks per bit.
    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       m_ready0 = 1'b0;
    logic       m_ready1 = 1'b0;
    logic [7:0] m_data0, m_data1;
    logic       m_valid0, m_valid1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       overflow0, overflow1;
    logic [3:0] count0, count1;

    int n_cmp = 0;
    int n_err = 0;
    int fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16),
        .DATA_BITS(8), .PARITY(0), .DEPTH(8)
    ) dut0 (
        .clk(clk), .rst(rst), .rx(rx0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
        .frame_err(frame_err0), .parity_err(parity_err0),
        .overflow(overflow0), .count(count0)
    );

    uart_rx_fifo #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16),
        .DATA_BITS(8), .PARITY(1), .DEPTH(8)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
        .frame_err(frame_err1), .parity_err(parity_err1),
        .overflow(overflow1), .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and pop scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err0)  fe0++;
        if (parity_err0) pe0++;
        if (overflow0)   ov0++;
        if (frame_err1)  fe1++;
        if (parity_err1) pe1++;
        if (overflow1)   ov1++;
        if (m_valid0 && m_ready0) begin
            if (exp0.size() == 0) check("pop0_unexpected", 32'(m_data0), 32'hFFFF_FFFF);
            else                  check("pop0_data", 32'(m_data0), 32'(exp0.pop_front()));
        end
        if (m_valid1 && m_ready1) begin
            if (exp1.size() == 0) check("pop1_unexpected", 32'(m_data1), 32'hFFFF_FFFF);
            else                  check("pop1_data", 32'(m_data1), 32'(exp1.pop_front()));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx1 = v; else rx0 = v;
        cycles(BIT_CLKS);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                        input logic par, input logic stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (use_par) drive(sel, par);
        drive(sel, stop);
        drive(sel, 1'b1);
    endtask

    task automatic pop_one(input bit sel);
        int n;
        n = 0;
        while (!(sel ? m_valid1 : m_valid0) && n < 200) begin
            cycles(1);
            n++;
        end
        check("pop_wait_valid", 32'(sel ? m_valid1 : m_valid0), 32'd1);
        if (sel) m_ready1 = 1'b1; else m_ready0 = 1'b1;
        cycles(1);
        m_ready0 = 1'b0;
        m_ready1 = 1'b0;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_before, fe_before, pe_before;
        cycles(5);
        check("rst_m_valid",  32'(m_valid0),    32'd0);
        check("rst_count",    32'(count0),      32'd0);
        check("rst_m_data",   32'(m_data0),     32'd0);
        check("rst_frame",    32'(frame_err0),  32'd0);
        check("rst_overflow", 32'(overflow0),   32'd0);
        check("rst_parity1",  32'(parity_err1), 32'd0);
        rst = 1'b1;
        cycles(20);

        // Single byte held until popped.
        send(0, 8'h72, 0, 1'b0, 1'b1);
        exp0.push_back(8'h72);
        check("t1_valid", 32'(m_valid0), 32'd1);
        check("t1_data",  32'(m_data0),  32'h72);
        check("t1_count", 32'(count0),   32'd1);
        cycles(200);
        check("t1_held",  32'(count0),   32'd1);
        pop_one(0);
        check("t1_count_after", 32'(count0), 32'd0);

        // Fill past capacity.
        for (int b = 1; b <= 8; b++) begin
            send(0, 8'(b), 0, 1'b0, 1'b1);
            exp0.push_back(8'(b));
        end
        check("t2_no_ovf_8", 32'(ov0), 32'd0);
        check("t2_count_8",  32'(count0), 32'd8);
        send(0, 8'h09, 0, 1'b0, 1'b1);
        check("t2_ovf_9",    32'(ov0), 32'd1);
        check("t2_count_9",  32'(count0), 32'd8);
        for (int b = 0; b < 8; b++) pop_one(0);
        check("t2_count_end", 32'(count0), 32'd0);

        // Bad stop bit, then a good byte.
        fe_before = fe0;
        send(0, 8'h63, 0, 1'b0, 1'b0);
        check("t3_frame_err", 32'(fe0 - fe_before), 32'd1);
        check("t3_count",     32'(count0), 32'd0);
        send(0, 8'h48, 0, 1'b0, 1'b1);
        exp0.push_back(8'h48);
        check("t3_count_good", 32'(count0), 32'd1);
        pop_one(0);

        // Parity mode: wrong then right parity.
        pe_before = pe1;
        send(1, 8'h48, 1, 1'b1, 1'b1);
        check("t4_parity_err", 32'(pe1 - pe_before), 32'd1);
        check("t4_count_bad",  32'(count1), 32'd0);
        send(1, 8'h48, 1, 1'b0, 1'b1);
        exp1.push_back(8'h48);
        check("t4_parity_ok",  32'(pe1 - pe_before), 32'd1);
        check("t4_count_good", 32'(count1), 32'd1);
        pop_one(1);
        check("t4_frame_err1", 32'(fe1), 32'd0);

        // Short glitch on rx is not a start bit.
        fe_before = fe0;
        rx0 = 1'b0;
        cycles(3 * BIT_CLKS / 16);
        rx0 = 1'b1;
        cycles(2 * BIT_CLKS);
        check("t5_no_push",  32'(count0), 32'd0);
        check("t5_no_frame", 32'(fe0 - fe_before), 32'd0);
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        exp0.push_back(8'hA5);
        pop_one(0);

        // Reset during data bit 4 of 0x4D.
        fe_before = fe0;
        pe_before = pe0;
        ov_before = ov0;
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, 1'((8'h4D >> i) & 8'h01));
        rx0 = 1'((8'h4D >> 4) & 8'h01);
        cycles(BIT_CLKS / 2);
        rst = 1'b0;
        cycles(5);
        rst = 1'b1;
        rx0 = 1'b1;
        cycles(2 * BIT_CLKS);
        check("t6_no_partial", 32'(count0), 32'd0);
        send(0, 8'h53, 0, 1'b0, 1'b1);
        exp0.push_back(8'h53);
        check("t6_count", 32'(count0), 32'd1);
        pop_one(0);
        check("t6_no_errs", 32'((fe0 - fe_before) + (pe0 - pe_before) + (ov0 - ov_before)), 32'd0);

        cycles(5);
        check("sb0_empty", 32'(exp0.size()), 32'd0);
        check("sb1_empty", 32'(exp1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: serial bit rate.
REQ-003 SHALL have parameter OVS, default 16: oversampling ticks per bit; even, minimum 8.
REQ-004 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter DEPTH, default 8: FIFO entries, power of 2, minimum 2.
REQ-007 SHALL have port clk, input, 1: the single system clock, rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-010 SHALL have port m_data, output, DATA_BITS: FIFO head byte.
REQ-011 SHALL have port m_valid, output, 1: FIFO is not empty.
REQ-012 SHALL have port m_ready, input, 1: consumer pop request.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-014 SHALL have port parity_err, output, 1: one-cycle pulse on a parity mismatch.
REQ-015 SHALL have port overflow, output, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-018 SHALL generate a one-cycle tick every round(CLK_HZ/(BAUD*OVS)) clocks.
- Divider free-runs in IDLE.
- Divider restarts on start-edge detection.
REQ-019 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- PARITY state is skipped when PARITY=0.
REQ-020 SHALL leave IDLE on a synchronized 1->0 edge of rx.
REQ-021 SHALL re-sample rx in START after OVS/2 ticks.
- rx high: treat as glitch and return to IDLE.
- rx low: go to DATA.
REQ-022 SHALL sample each data bit, parity bit and stop bit every OVS ticks after the start mid-point; data is LSB first.
REQ-023 SHALL handle a stop sample of 0 as follows.
- Pulse frame_err.
- Discard the byte.
- Stay in STOP until rx is high, then go to IDLE.
REQ-024 SHALL pulse parity_err and discard the byte on a parity mismatch; the stop bit is still checked.
- If both errors occur, SHALL pulse both in the same cycle.
REQ-025 SHALL push a good byte into the FIFO in the clock after the stop sample.
- m_valid rises in the following clock.
REQ-026 SHALL make the FIFO first-word fall-through.
- m_data is valid whenever m_valid=1.
- A pop occurs on m_valid & m_ready.
- m_ready while empty is ignored.
REQ-027 SHALL handle a push while full as follows.
- If a pop occurs in the same cycle: perform both, count unchanged, no overflow.
- Otherwise: drop the byte, pulse overflow, leave the FIFO contents unchanged.
REQ-028 SHALL wrap the FIFO pointers modulo DEPTH; count SHALL be 0..DEPTH.
REQ-029 SHALL accept a new start edge immediately after a valid stop sample; no extra idle time is required.

Reset
REQ-030 SHALL, while rst=0, force the following states.
- FSM to IDLE.
- Tick divider, bit counter, FIFO pointers and count to 0.
- Synchronizer flops to 1.
- m_data, m_valid, frame_err, parity_err and overflow to 0.
REQ-031 SHALL abandon any frame in progress when reset is asserted mid-frame.
- No partial byte is pushed.
- No error pulse is generated.
- After release, the block waits for a new start edge.

Structure
REQ-032 SHALL take its shared types from package uart_pkg, containing:
- parity mode constants;
- the rx state enumeration;
- a divisor-calculation function.
REQ-033 SHALL instantiate the FIFO as sub-module sync_fifo, parameterised by WIDTH and DEPTH; the receiver FSM stays in uart_rx_fifo.

Verification (CLK_HZ=100e6, BAUD=9600, OVS=16, bit time 104166 ns)
REQ-034 SHALL cover: send 0x72 ('r'), PARITY=0, m_ready=0 -> m_valid=1, m_data=0x72, count=1; it stays held until m_ready is pulsed, then count=0.
REQ-035 SHALL cover: send 9 bytes 0x01..0x09 with m_ready=0, DEPTH=8 -> one overflow pulse on the 9th byte; popping returns 0x01..0x08 in order.
REQ-036 SHALL cover: send 0x63 ('c') with the stop bit driven 0 -> one frame_err pulse, count stays 0; the next valid 0x48 is received correctly.
REQ-037 SHALL cover: PARITY=1, send 0x48 with parity bit 1 -> one parity_err pulse, nothing pushed; send 0x48 with parity bit 0 -> 0x48 pushed.
REQ-038 SHALL cover: rx low pulse lasting 3 bit-times/16 -> no start and no push; the FSM returns to IDLE.
REQ-039 SHALL cover: assert rst during data bit 4 of 0x4D, release, then send 0x53 -> only 0x53 is received, with no error pulses.
